// File: rtl/my_dff8.sv
// 8-bit masked D register with sync clear, change pulse and optional parity.
// Define MY_DFF8_PARITY_EN to build the registered even-parity output.
module my_dff8_bit #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic wmask,
    input  logic d,
    output logic q,
    output logic nxt
);

    logic r_q;

    // clr wins over en and ignores the mask
    always_comb begin
        nxt = r_q;
        if (clr)
            nxt = RST_BIT;
        else if (en && wmask)
            nxt = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= RST_BIT;
        else
            r_q <= nxt;
    end

    assign q = r_q;

endmodule

module my_dff8 #(
    parameter logic [7:0] RESET_VAL = 8'h00,
    parameter int         CHG_PULSE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] wmask,
    input  logic [7:0] d,
    output logic [7:0] q,
    output logic       changed,
    output logic       par
);

    logic [7:0] w_q;
    logic [7:0] w_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            my_dff8_bit #(.RST_BIT(RESET_VAL[gi])) u_bit (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr),
                .en    (en),
                .wmask (wmask[gi]),
                .d     (d[gi]),
                .q     (w_q[gi]),
                .nxt   (w_nxt[gi])
            );
        end
    endgenerate

    assign q = w_q;

    generate
        if (CHG_PULSE != 0) begin : g_chg
            logic r_changed;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_changed <= 1'b0;
                else
                    r_changed <= |(w_nxt ^ w_q);
            end
            assign changed = r_changed;
        end else begin : g_nochg
            assign changed = 1'b0;
        end
    endgenerate

`ifdef MY_DFF8_PARITY_EN
    // Parity of the incoming value so par tracks q in the same cycle
    logic r_par;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_par <= ^RESET_VAL;
        else
            r_par <= ^w_nxt;
    end
    assign par = r_par;
`else
    assign par = 1'b0;
`endif

endmodule

// File: tb/tb_my_dff8.sv
// Self-checking bench for my_dff8: directed scenarios plus randomized traffic
// against a per-bit behavioural model.
module tb_my_dff8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [7:0] wmask;
    logic [7:0] d;
    logic [7:0] q;
    logic       changed;
    logic       par;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_q;
    logic       m_chg;

    my_dff8 #(.RESET_VAL(8'h00), .CHG_PULSE(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (clr),
        .wmask   (wmask),
        .d       (d),
        .q       (q),
        .changed (changed),
        .par     (par)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic exp_par(input logic [7:0] v);
`ifdef MY_DFF8_PARITY_EN
        return ($countones(v) % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    // Apply inputs, take one edge, advance the model, settle 1 ns past the edge
    task automatic cyc(input logic i_en, input logic i_clr, input logic [7:0] i_wm,
                       input logic [7:0] i_d);
        logic [7:0] nq;
        en = i_en; clr = i_clr; wmask = i_wm; d = i_d;
        @(posedge clk);
        nq = m_q;
        for (int b = 0; b < 8; b++) begin
            if (i_clr)                 nq[b] = 1'b0;
            else if (i_en && i_wm[b])  nq[b] = i_d[b];
        end
        m_chg = (nq != m_q);
        m_q   = nq;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; wmask = 8'h00; d = 8'h00;
        #3;
        total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q act=%h exp=00", q); end
        total++; if (changed !== 1'b0) begin bad++; $display("FAIL reset_chg act=%b exp=0", changed); end
        total++; if (par !== exp_par(8'h00)) begin bad++; $display("FAIL reset_par act=%b exp=%b", par, exp_par(8'h00)); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_q = 8'h00; m_chg = 1'b0;
    endtask

    task automatic test_basic_load;
        logic [7:0] vals [4] = '{8'h01, 8'h02, 8'hFF, 8'hAA};
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0, 8'hFF, vals[k]);
            total++; if (q !== vals[k]) begin bad++; $display("FAIL basic_q[%0d] act=%h exp=%h", k, q, vals[k]); end
            total++; if (changed !== 1'b1) begin bad++; $display("FAIL basic_chg[%0d] act=%b exp=1", k, changed); end
        end
    endtask

    task automatic test_async_reset;
        cyc(1'b1, 1'b0, 8'hFF, 8'hAA);
        #2 rst_n = 1'b0;
        #1;
        total++; if (q !== 8'h00) begin bad++; $display("FAIL arst_q act=%h exp=00", q); end
        total++; if (changed !== 1'b0) begin bad++; $display("FAIL arst_chg act=%b exp=0", changed); end
        en = 1'b1; clr = 1'b0; wmask = 8'hFF; d = 8'h55;
        @(posedge clk); #1;
        total++; if (q !== 8'h00) begin bad++; $display("FAIL arst_hold act=%h exp=00", q); end
        rst_n = 1'b1;
        m_q = 8'h00; m_chg = 1'b0;
        cyc(1'b1, 1'b0, 8'hFF, 8'h55);
        total++; if (q !== 8'h55) begin bad++; $display("FAIL arst_load act=%h exp=55", q); end
    endtask

    task automatic test_mask_enable;
        cyc(1'b1, 1'b0, 8'hFF, 8'hFF);
        cyc(1'b1, 1'b0, 8'h0F, 8'h00);
        total++; if (q !== 8'hF0) begin bad++; $display("FAIL mask_q act=%h exp=F0", q); end
        total++; if (changed !== 1'b1) begin bad++; $display("FAIL mask_chg act=%b exp=1", changed); end
        cyc(1'b0, 1'b0, 8'hFF, 8'h12);
        total++; if (q !== 8'hF0) begin bad++; $display("FAIL en0_q act=%h exp=F0", q); end
        total++; if (changed !== 1'b0) begin bad++; $display("FAIL en0_chg act=%b exp=0", changed); end
        cyc(1'b1, 1'b0, 8'h00, 8'h0F);
        total++; if (q !== 8'hF0) begin bad++; $display("FAIL wm0_q act=%h exp=F0", q); end
        total++; if (changed !== 1'b0) begin bad++; $display("FAIL wm0_chg act=%b exp=0", changed); end
    endtask

    task automatic test_clear;
        cyc(1'b1, 1'b0, 8'hFF, 8'h3C);
        cyc(1'b1, 1'b1, 8'hFF, 8'hFF);
        total++; if (q !== 8'h00) begin bad++; $display("FAIL clr_q act=%h exp=00", q); end
        total++; if (changed !== 1'b1) begin bad++; $display("FAIL clr_chg act=%b exp=1", changed); end
        cyc(1'b1, 1'b1, 8'h00, 8'hFF);
        total++; if (q !== 8'h00) begin bad++; $display("FAIL clr2_q act=%h exp=00", q); end
        total++; if (changed !== 1'b0) begin bad++; $display("FAIL clr2_chg act=%b exp=0", changed); end
    endtask

    task automatic test_parity;
        cyc(1'b1, 1'b0, 8'hFF, 8'h07);
        total++; if (par !== exp_par(8'h07)) begin bad++; $display("FAIL par07 act=%b exp=%b", par, exp_par(8'h07)); end
        cyc(1'b1, 1'b0, 8'hFF, 8'h03);
        total++; if (par !== exp_par(8'h03)) begin bad++; $display("FAIL par03 act=%b exp=%b", par, exp_par(8'h03)); end
    endtask

    task automatic test_same_value;
        cyc(1'b1, 1'b0, 8'hFF, 8'hAA);
        cyc(1'b1, 1'b0, 8'hFF, 8'hAA);
        total++; if (q !== 8'hAA) begin bad++; $display("FAIL same_q act=%h exp=AA", q); end
        total++; if (changed !== 1'b0) begin bad++; $display("FAIL same_chg act=%b exp=0", changed); end
    endtask

    task automatic test_random;
        for (int n = 0; n < 300; n++) begin
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                8'($urandom), 8'($urandom));
            total++; if (q !== m_q) begin bad++; $display("FAIL rnd_q[%0d] act=%h exp=%h", n, q, m_q); end
            total++; if (changed !== m_chg) begin bad++; $display("FAIL rnd_chg[%0d] act=%b exp=%b", n, changed, m_chg); end
            total++; if (par !== exp_par(m_q)) begin bad++; $display("FAIL rnd_par[%0d] act=%b exp=%b", n, par, exp_par(m_q)); end
        end
    endtask

    initial begin
        m_q = 8'h00; m_chg = 1'b0;
        test_reset;
        test_basic_load;
        test_async_reset;
        test_mask_enable;
        test_clear;
        test_parity;
        test_same_value;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/my_dff8.md
MY_DFF8 -- requirements
Module: my_dff8

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter RESET_VAL, default 8'h00, giving the value q takes on reset and on synchronous clear.
REQ-002 The block SHALL have parameter CHG_PULSE, default 1, where 1 enables the changed output and 0 forces it to 0.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port en, input, 1, the load enable.
REQ-006 The block SHALL have port clr, input, 1, the synchronous clear to RESET_VAL.
REQ-007 The block SHALL have port wmask, input, 8, the per-bit write mask, where 1 means the bit loads.
REQ-008 The block SHALL have port d, input, 8, the data in.
REQ-009 The block SHALL have port q, output, 8, the registered data out.
REQ-010 The block SHALL have port changed, output, 1, a registered one-cycle pulse that is high when q changed on the last edge.
REQ-011 The block SHALL have port par, output, 1, the registered even-parity bit of q; it is present only under the configuration macro in REQ-023.
REQ-012 Instantiations that use the block as a plain 8-bit DFF SHALL tie en=1, clr=0, wmask=8'hFF; that pure D-register behaviour is the primary use case.

Function
REQ-013 On each rising clk edge with rst_n=1, clr=0 and en=1, q[i] SHALL take d[i] for every bit where wmask[i]=1, and hold for every bit where wmask[i]=0.
REQ-014 The block SHALL have one-edge latency: d applied before edge N is visible on q immediately after edge N; q SHALL NOT respond combinationally to d.
REQ-015 With en=0 and clr=0, q SHALL hold regardless of d and wmask.
REQ-016 clr=1 SHALL load RESET_VAL into all 8 bits on the edge, with priority over en and ignoring wmask.
REQ-017 With wmask=8'h00 and en=1, q SHALL hold, and this SHALL NOT count as a change.
REQ-018 changed SHALL be 1 for exactly the cycle following an edge on which the new q differs from the old q, and 0 otherwise. Reloading an identical value gives changed=0. A clr that alters q gives changed=1.
REQ-019 When CHG_PULSE=0, changed SHALL be constant 0.
REQ-020 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-021 rst_n=0 SHALL immediately, without waiting for clk, force q=RESET_VAL, changed=0 and par=^RESET_VAL (or 0 when the macro is absent).
REQ-022 While rst_n=0, clock edges SHALL be ignored; after rst_n deasserts, the first rising edge SHALL operate normally. Reset mid-operation SHALL discard any pending load.

Configuration
REQ-023 When macro MY_DFF8_PARITY_EN is defined, par SHALL be a flop updated on the same edge as q, holding the XOR of all 8 bits of the new q, so it always matches q in the same cycle.
REQ-024 When MY_DFF8_PARITY_EN is undefined, the par port SHALL remain but be tied to constant 0, and no parity logic SHALL be generated.

Verification
REQ-025 The bench SHALL cover basic load: en=1, wmask=FF, clr=0, apply d=8'h01, 8'h02, 8'hFF, 8'hAA on successive 10 ns clock periods, sampling at each period end -> q=01, 02, FF, AA respectively, and changed=1 after each edge.
REQ-026 The bench SHALL cover async reset: with q=8'hAA, drive rst_n=0 between clock edges -> q=8'h00 and changed=0 immediately; release, load d=8'h55 -> q=55 after the next edge.
REQ-027 The bench SHALL cover mask and enable: q=8'hFF, wmask=8'h0F, d=8'h00, en=1 -> q=F0. Then en=0 with d=8'h12 -> q stays F0 and changed=0.
REQ-028 The bench SHALL cover clear priority: q=8'h3C, clr=1, en=1, d=8'hFF -> q=RESET_VAL (00) and changed=1. Then clr=1 again -> q=00 and changed=0.
REQ-029 The bench SHALL cover parity: with MY_DFF8_PARITY_EN defined, load d=8'h07 -> par=1, load d=8'h03 -> par=0. Without the macro -> par=0 throughout.
REQ-030 The bench SHALL cover same-value reload: q=8'hAA, load d=8'hAA -> q=AA and changed=0.
